mips_cpu_bus_lsu: RTL and testbench

Load/store unit sitting directly upstream of the data-side Avalon-style memory bus. It takes one load/store request at a time from the MIPS datapath (LB/LBU/LH/LHU/LW/SB/SH/SW), generates the word-aligned address, byteenable and lane-positioned writedata, and honours waitrequest. For loads it samples readdata after a fixed latency and returns a sign- or zero-extended 32-bit result to the register writeback path.

---
 rtl/mips_cpu_bus_pkg.sv | 43 ++++
 rtl/mips_cpu_bus_lsu_align.sv | 37 +++
 rtl/mips_cpu_bus_lsu.sv | 146 ++++++++++++++
 tb/tb_mips_cpu_bus_lsu.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_bus_pkg.sv
// rtl/mips_cpu_bus_pkg.sv - shared types and lane helpers for the data-side bus LSU
package mips_cpu_bus_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LBU = 3'd1,
    LH  = 3'd2,
    LHU = 3'd3,
    LW  = 3'd4,
    SB  = 3'd5,
    SH  = 3'd6,
    SW  = 3'd7
  } lsu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } lsu_state_t;

  function automatic logic [3:0] lsu_byteenable(input lsu_op_t op, input logic [1:0] addr_lo);
    case (op)
      LB, LBU, SB: return 4'b0001 << addr_lo;
      LH, LHU, SH: return addr_lo[1] ? 4'b1100 : 4'b0011;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input lsu_op_t op, input logic [1:0] addr_lo);
    case (op)
      LH, LHU, SH: return addr_lo[0];
      LW, SW:      return |addr_lo;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic lsu_is_store(input lsu_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

endpackage

// File: rtl/mips_cpu_bus_lsu_align.sv
// rtl/mips_cpu_bus_lsu_align.sv - combinational store lane replication and load extract/extend
module mips_cpu_bus_lsu_align
  import mips_cpu_bus_pkg::*;
(
  input  lsu_op_t     op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] load_lanes_i,
  output logic [31:0] store_lanes_o,
  output logic [31:0] load_data_o
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted  = load_lanes_i >> {addr_lo_i, 3'b000};
    byte_sel = shifted[7:0];
    half_sel = addr_lo_i[1] ? load_lanes_i[31:16] : load_lanes_i[15:0];

    case (op_i)
      LB:      load_data_o = {{24{byte_sel[7]}}, byte_sel};
      LBU:     load_data_o = {24'h0, byte_sel};
      LH:      load_data_o = {{16{half_sel[15]}}, half_sel};
      LHU:     load_data_o = {16'h0, half_sel};
      default: load_data_o = load_lanes_i;
    endcase

    case (op_i)
      SB:      store_lanes_o = {4{store_data_i[7:0]}};
      SH:      store_lanes_o = {2{store_data_i[15:0]}};
      default: store_lanes_o = store_data_i;
    endcase
  end

endmodule

// File: rtl/mips_cpu_bus_lsu.sv
// rtl/mips_cpu_bus_lsu.sv - single-outstanding load/store unit on an Avalon-style data bus
// Optional waitrequest watchdog enabled by defining MIPS_LSU_TIMEOUT_EN.
module mips_cpu_bus_lsu
  import mips_cpu_bus_pkg::*;
#(
  parameter int READ_LATENCY   = 1,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  lsu_op_t     req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic        waitrequest,
  input  logic [31:0] readdata
);

  localparam logic [1:0] LAT_LAST = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

  lsu_state_t  state_q, state_d;
  lsu_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  be_q, be_d;
  logic        err_q, err_d;
  logic [1:0]  lat_q, lat_d;
  logic [31:0] load_data;
  logic        timeout_hit;

`ifdef MIPS_LSU_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 : $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] stall_q, stall_d;

  // Counts consecutive stalled cycles of the current strobe only.
  always_comb begin
    stall_d = '0;
    if ((state_q == ST_RD_REQ || state_q == ST_WR_REQ) && waitrequest)
      stall_d = stall_q + 1'b1;
  end
  assign timeout_hit = waitrequest && (stall_q == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  mips_cpu_bus_lsu_align u_align (
    .op_i          (op_q),
    .addr_lo_i     (addr_q[1:0]),
    .store_data_i  (wdata_q),
    .load_lanes_i  (readdata),
    .store_lanes_o (writedata),
    .load_data_o   (load_data)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    be_d    = be_q;
    err_d   = err_q;
    lat_d   = lat_q;
    unique case (state_q)
      ST_IDLE: if (req_valid) begin
        op_d    = req_op;
        addr_d  = req_addr;
        wdata_d = req_wdata;
        be_d    = lsu_byteenable(req_op, req_addr[1:0]);
        rdata_d = '0;
        err_d   = 1'b0;
        lat_d   = '0;
        if (lsu_misaligned(req_op, req_addr[1:0])) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else if (lsu_is_store(req_op)) state_d = ST_WR_REQ;
        else                               state_d = ST_RD_REQ;
      end
      ST_RD_REQ: if (!waitrequest) begin
        if (READ_LATENCY == 0) begin
          rdata_d = load_data;
          state_d = ST_DONE;
        end else state_d = ST_RD_WAIT;
      end else if (timeout_hit) begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_RD_WAIT: if (lat_q == LAT_LAST) begin
        rdata_d = load_data;
        state_d = ST_DONE;
      end else lat_d = lat_q + 2'd1;
      ST_WR_REQ: if (!waitrequest) state_d = ST_DONE;
      else if (timeout_hit) begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      op_q    <= LB;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      be_q    <= '0;
      err_q   <= 1'b0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      be_q    <= be_d;
      err_q   <= err_d;
      lat_q   <= lat_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign read       = (state_q == ST_RD_REQ);
  assign write      = (state_q == ST_WR_REQ);
  assign address    = {addr_q[31:2], 2'b00};
  assign byteenable = be_q;
  assign resp_valid = (state_q == ST_DONE);
  assign resp_err   = (state_q == ST_DONE) && err_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mips_cpu_bus_lsu.sv
// tb/tb_mips_cpu_bus_lsu.sv - scoreboard bench for mips_cpu_bus_lsu with directed vectors
module tb_mips_cpu_bus_lsu;
  import mips_cpu_bus_pkg::*;

`ifdef MIPS_LSU_TIMEOUT_EN
  localparam int TB_TIMEOUT = 4;
`else
  localparam int TB_TIMEOUT = 255;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  lsu_op_t     req_op;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        read, write, waitrequest;
  logic [3:0]  byteenable;

  mips_cpu_bus_lsu #(.READ_LATENCY(1), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .address(address), .read(read), .write(write), .byteenable(byteenable),
    .writedata(writedata), .waitrequest(waitrequest), .readdata(readdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   resp_seen = 0;
  int   seen_at_issue = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expected response per observed resp_valid pulse.
  always @(negedge clk) begin
    if (!reset && resp_valid) begin
      resp_seen++;
      if (q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("resp_rdata", resp_rdata, e.rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        chk("resp_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic issue(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat, input bit push);
    exp_t e;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    seen_at_issue = resp_seen;
    if (push) begin
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic bus_chk(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [3:0] be, input logic [31:0] wd);
    chk("read", {31'd0, read}, {31'd0, rd});
    chk("write", {31'd0, write}, {31'd0, wr});
    chk("address", address, a);
    chk("byteenable", {28'd0, byteenable}, {28'd0, be});
    chk("writedata", writedata, wd);
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 40 && resp_seen == seen_at_issue; i++) @(negedge clk);
    chk("resp_arrived", {31'd0, resp_seen != seen_at_issue}, 32'd1);
  endtask

  task automatic load(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] rd,
                      input logic [3:0] be, input logic [31:0] exp);
    readdata = rd;
    issue(op, addr, 32'h0, exp, 1'b0, 3, 1'b1);
    @(negedge clk);
    bus_chk(1'b1, 1'b0, {addr[31:2], 2'b00}, be, 32'h0);
    wait_resp();
  endtask

  task automatic store(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] lanes);
    issue(op, addr, wd, 32'h0, 1'b0, 2, 1'b1);
    @(negedge clk);
    bus_chk(1'b0, 1'b1, {addr[31:2], 2'b00}, be, lanes);
    wait_resp();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = LB; req_addr = '0; req_wdata = '0;
    waitrequest = 1'b0; readdata = '0;
    repeat (2) @(negedge clk);
    bus_chk(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_err", {31'd0, resp_err}, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("req_ready_after_reset", {31'd0, req_ready}, 32'd1);

    load(LW,  32'h100, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    load(LB,  32'h103, 32'h80FF7F01, 4'b1000, 32'hFFFFFF80);
    load(LBU, 32'h103, 32'h80FF7F01, 4'b1000, 32'h00000080);
    load(LH,  32'h102, 32'h80FF7F01, 4'b1100, 32'hFFFF80FF);
    load(LHU, 32'h100, 32'h80FF7F01, 4'b0011, 32'h00007F01);
    load(LB,  32'h101, 32'h80FF7F01, 4'b0010, 32'h0000007F);

    store(SH, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD);
    store(SB, 32'h201, 32'h000000A5, 4'b0010, 32'hA5A5A5A5);
    store(SW, 32'h300, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D);

    // LW with three stall cycles: accept at end of cycle 4, response cycle 6.
    readdata = 32'h12345678;
    waitrequest = 1'b1;
    issue(LW, 32'h104, 32'h0, 32'h12345678, 1'b0, 6, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus_chk(1'b1, 1'b0, 32'h104, 4'b1111, 32'h0);
    end
    @(negedge clk);
    chk("read_held_c4", {31'd0, read}, 32'd1);
    waitrequest = 1'b0;
    wait_resp();

    issue(SW, 32'h301, 32'hCAFEF00D, 32'h0, 1'b1, 1, 1'b1);
    @(negedge clk);
    chk("misaligned_sw_no_write", {31'd0, write}, 32'd0);
    chk("misaligned_sw_no_read", {31'd0, read}, 32'd0);
    wait_resp();

    issue(LH, 32'h101, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    @(negedge clk);
    chk("misaligned_lh_no_read", {31'd0, read}, 32'd0);
    wait_resp();

`ifdef MIPS_LSU_TIMEOUT_EN
    waitrequest = 1'b1;
    issue(LW, 32'h10C, 32'h0, 32'h0, 1'b1, 5, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("timeout_read_held", {31'd0, read}, 32'd1);
    end
    @(negedge clk);
    chk("timeout_read_dropped", {31'd0, read}, 32'd0);
    wait_resp();
    waitrequest = 1'b0;
`endif

    // Reset during a stalled read: strobe must drop without a clock edge.
    waitrequest = 1'b1;
    issue(LW, 32'h108, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    @(negedge clk);
    chk("stall_read_before_reset", {31'd0, read}, 32'd1);
    #3 reset = 1'b1;
    #1 chk("read_dropped_async", {31'd0, read}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    waitrequest = 1'b0;
    #1 chk("req_ready_after_midreset", {31'd0, req_ready}, 32'd1);
    repeat (4) @(negedge clk);
    chk("no_resp_after_reset", resp_seen, seen_at_issue);

    chk("queue_empty", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
